// File: rtl/conv_core_pipe.sv
// Pipelined 1-D convolution / cross-correlation core: Z[n] = sum_k X[k]*Yi[n-k], one MAC term per cycle.
// Define CONV_SAT_EN to saturate dataZ at all-ones instead of truncating the accumulator.
module conv_core_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int Z_WIDTH    = 16,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH:0]   size_x,
    input  logic [ADDR_WIDTH:0]   size_y,
    output logic [ADDR_WIDTH-1:0] memX_addr,
    output logic                  memX_rd,
    input  logic [DATA_WIDTH-1:0] dataX,
    output logic [ADDR_WIDTH-1:0] memY_addr,
    output logic                  memY_rd,
    input  logic [DATA_WIDTH-1:0] dataY,
    output logic [ADDR_WIDTH:0]   memZ_addr,
    output logic [Z_WIDTH-1:0]    dataZ,
    output logic                  writeZ,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int N_W    = ADDR_WIDTH + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + ADDR_WIDTH;

    localparam logic [N_W-1:0] ZERO_N  = {N_W{1'b0}};
    localparam logic [N_W-1:0] ONE_N   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [N_W-1:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [1:0]     DRAIN_LAST = 2'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [N_W-1:0] k_min(input logic [N_W-1:0] n, input logic [N_W-1:0] sy);
        if (n >= sy) return n - sy + ONE_N;
        else         return ZERO_N;
    endfunction

    function automatic logic [N_W-1:0] k_max(input logic [N_W-1:0] n, input logic [N_W-1:0] sx);
        if (n < sx) return n;
        else        return sx - ONE_N;
    endfunction

    // Cross-correlation walks Y backwards from its last sample.
    function automatic logic [ADDR_WIDTH-1:0] y_addr(input logic [N_W-1:0] n, input logic [N_W-1:0] k,
                                                     input logic [N_W-1:0] sy, input logic rev);
        logic [N_W-1:0] j;
        j = n - k;
        if (rev) return ADDR_WIDTH'(sy - ONE_N - j);
        else     return ADDR_WIDTH'(j);
    endfunction

    function automatic logic [Z_WIDTH-1:0] z_out(input logic [ACC_W-1:0] acc);
`ifdef CONV_SAT_EN
        if ((ACC_W + Z_WIDTH)'(acc) > (ACC_W + Z_WIDTH)'({Z_WIDTH{1'b1}})) return {Z_WIDTH{1'b1}};
        else                                                             return Z_WIDTH'(acc);
`else
        return Z_WIDTH'(acc);
`endif
    endfunction

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [N_W-1:0]        sx_q, sx_d, sy_q, sy_d, n_q, n_d, k_q, k_d;
    logic [1:0]            drain_q, drain_d;
    logic                  rd_q, rd_d, first_q, first_d;
    logic [MEM_LAT-1:0]    pv_q, pv_d, pf_q, pf_d;
    logic [PROD_W-1:0]     prod_q, prod_d;
    logic                  prodv_q, prodv_d, prodf_q, prodf_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] xaddr_q, xaddr_d, yaddr_q, yaddr_d;
    logic [N_W-1:0]        zaddr_q, zaddr_d;
    logic [Z_WIDTH-1:0]    dataz_q, dataz_d;
    logic                  writez_q, writez_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Sequencer: run acceptance, term index k, output index n and drain timing.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        n_d     = n_q;
        k_d     = k_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_x == ZERO_N || size_y == ZERO_N || size_x > LEN_MAX || size_y > LEN_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        sx_d    = size_x;
                        sy_d    = size_y;
                        n_d     = ZERO_N;
                        k_d     = ZERO_N;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (k_q == k_max(n_q, sx_q)) begin
                    drain_d = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + ONE_N;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_WRITE;
                else                       drain_d = drain_q + 2'd1;
            end
            S_WRITE: begin
                n_d = n_q + ONE_N;
                // SX+SY may wrap in N_W bits; n_d wraps identically so the compare still holds.
                if (n_d == sx_q + sy_q - ONE_N) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_min(n_d, sy_q);
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read strobes, product/accumulate pipeline and registered output values.
    always_comb begin
        rd_d    = (state_d == S_ISSUE);
        first_d = rd_d && (state_q != S_ISSUE);
        if (rd_d) begin
            xaddr_d = ADDR_WIDTH'(k_d);
            yaddr_d = y_addr(n_d, k_d, sy_d, mode_d);
        end else begin
            xaddr_d = {ADDR_WIDTH{1'b0}};
            yaddr_d = {ADDR_WIDTH{1'b0}};
        end

        pv_d[0] = rd_q;
        pf_d[0] = first_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pf_d[i] = pf_q[i-1];
        end

        prodv_d = pv_q[MEM_LAT-1];
        prodf_d = pf_q[MEM_LAT-1];
        if (pv_q[MEM_LAT-1]) prod_d = PROD_W'(dataX) * PROD_W'(dataY);
        else                 prod_d = prod_q;

        if (prodv_q) begin
            if (prodf_q) acc_d = ACC_W'(prod_q);
            else         acc_d = acc_q + ACC_W'(prod_q);
        end else begin
            acc_d = acc_q;
        end

        writez_d = (state_d == S_WRITE);
        if (writez_d) begin
            zaddr_d = n_q;
            dataz_d = z_out(acc_d);
        end else begin
            zaddr_d = ZERO_N;
            dataz_d = {Z_WIDTH{1'b0}};
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            sx_q     <= ZERO_N;
            sy_q     <= ZERO_N;
            n_q      <= ZERO_N;
            k_q      <= ZERO_N;
            drain_q  <= 2'd0;
            rd_q     <= 1'b0;
            first_q  <= 1'b0;
            pv_q     <= {MEM_LAT{1'b0}};
            pf_q     <= {MEM_LAT{1'b0}};
            prod_q   <= {PROD_W{1'b0}};
            prodv_q  <= 1'b0;
            prodf_q  <= 1'b0;
            acc_q    <= {ACC_W{1'b0}};
            xaddr_q  <= {ADDR_WIDTH{1'b0}};
            yaddr_q  <= {ADDR_WIDTH{1'b0}};
            zaddr_q  <= ZERO_N;
            dataz_q  <= {Z_WIDTH{1'b0}};
            writez_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            n_q      <= n_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            rd_q     <= rd_d;
            first_q  <= first_d;
            pv_q     <= pv_d;
            pf_q     <= pf_d;
            prod_q   <= prod_d;
            prodv_q  <= prodv_d;
            prodf_q  <= prodf_d;
            acc_q    <= acc_d;
            xaddr_q  <= xaddr_d;
            yaddr_q  <= yaddr_d;
            zaddr_q  <= zaddr_d;
            dataz_q  <= dataz_d;
            writez_q <= writez_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign memX_addr = xaddr_q;
    assign memX_rd   = rd_q;
    assign memY_addr = yaddr_q;
    assign memY_rd   = rd_q;
    assign memZ_addr = zaddr_q;
    assign dataZ     = dataz_q;
    assign writeZ    = writez_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_core_pipe.sv
// Scoreboard bench for conv_core_pipe: X/Y RAM models with MEM_LAT latency, expected Z queued at launch.
module tb_conv_core_pipe #(parameter int MEM_LAT = 1);

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int ZW = 16;

    logic          clk = 1'b0;
    logic          rstn, start, mode;
    logic [AW:0]   size_x, size_y;
    logic [AW-1:0] memX_addr, memY_addr;
    logic          memX_rd, memY_rd;
    logic [DW-1:0] dataX, dataY;
    logic [AW:0]   memZ_addr;
    logic [ZW-1:0] dataZ;
    logic          writeZ, busy, done, err;

    conv_core_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Z_WIDTH(ZW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .size_x(size_x), .size_y(size_y),
        .memX_addr(memX_addr), .memX_rd(memX_rd), .dataX(dataX),
        .memY_addr(memY_addr), .memY_rd(memY_rd), .dataY(dataY),
        .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] xmem [0:31];
    logic [DW-1:0] ymem [0:31];
    logic [DW-1:0] xpipe [0:MEM_LAT-1];
    logic [DW-1:0] ypipe [0:MEM_LAT-1];

    // Synchronous-read RAMs; garbage is presented whenever no read is in flight.
    always @(posedge clk) begin
        xpipe[0] <= memX_rd ? xmem[memX_addr] : DW'($urandom);
        ypipe[0] <= memY_rd ? ymem[memY_addr] : DW'($urandom);
        for (int i = 1; i < MEM_LAT; i++) begin
            xpipe[i] <= xpipe[i-1];
            ypipe[i] <= ypipe[i-1];
        end
    end
    assign dataX = xpipe[MEM_LAT-1];
    assign dataY = ypipe[MEM_LAT-1];

    typedef struct {
        logic [AW:0]   addr;
        logic [ZW-1:0] data;
        int            gap;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_w = 0;
    logic          busy_prev = 1'b0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            wr_cnt = 0;
    int            cur_sx = 1;
    int            cur_sy = 1;
    logic [ZW-1:0] z_seen [0:63];
    int            t1_z [0:3] = '{4, 13, 22, 15};
    int            t2_z [0:3] = '{5, 14, 23, 12};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge and check every output event.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (busy && !busy_prev) last_w = cyc - 1;
        busy_prev = busy;
        if (memX_rd || memY_rd) begin
            check_eq("rd_sync", memY_rd, memX_rd);
            check_eq("x_addr_range", (int'(memX_addr) < cur_sx), 1);
            check_eq("y_addr_range", (int'(memY_addr) < cur_sy), 1);
            check_eq("rd_while_busy", busy, 1);
        end
        if (writeZ) begin
            wr_cnt++;
            check_eq("sb_nonempty_at_write", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("z_addr", memZ_addr, e.addr);
                check_eq("z_data", dataZ, e.data);
                check_eq("z_latency", cyc - last_w, e.gap);
                z_seen[memZ_addr] = dataZ;
            end
            last_w = cyc;
        end
        if (done) begin
            done_cnt++;
            check_eq("busy_low_at_done", busy, 0);
        end
        if (err) err_cnt++;
    endtask

    task automatic push_exp(input int sx, input int sy, input bit md);
        exp_t   e;
        longint acc;
        int     terms;
        for (int n = 0; n <= sx + sy - 2; n++) begin
            acc = 0;
            terms = 0;
            for (int k = 0; k < sx; k++) begin
                if (n - k >= 0 && n - k < sy) begin
                    acc += longint'(xmem[k]) * longint'(md ? ymem[sy - 1 - (n - k)] : ymem[n - k]);
                    terms++;
                end
            end
            e.addr = (AW + 1)'(n);
`ifdef CONV_SAT_EN
            e.data = (acc >= (longint'(1) << ZW)) ? {ZW{1'b1}} : ZW'(acc);
`else
            e.data = ZW'(acc);
`endif
            e.gap = terms + MEM_LAT + 2;
            sb.push_back(e);
        end
    endtask

    task automatic launch(input int sx, input int sy, input bit md);
        cur_sx = sx;
        cur_sy = sy;
        size_x = (AW + 1)'(sx);
        size_y = (AW + 1)'(sy);
        mode   = md;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        size_x = (AW + 1)'($urandom);
        size_y = (AW + 1)'($urandom);
        mode   = ~md;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        check_eq("done_seen", done_cnt - d0, 1);
        check_eq("sb_drained", sb.size(), 0);
        tick();
        check_eq("busy_after_done", busy, 0);
        check_eq("single_done_pulse", done_cnt - d0, 1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {memX_addr, memX_rd, memY_addr, memY_rd, memZ_addr, dataZ, writeZ, busy, done, err}, 0);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 32; i++) begin
            xmem[i] = 8'd0;
            ymem[i] = 8'd0;
        end
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd4; ymem[1] = 8'd5;
    endtask

    task automatic load_random();
        for (int i = 0; i < 32; i++) begin
            xmem[i] = DW'($urandom);
            ymem[i] = DW'($urandom);
        end
    endtask

    initial begin
        int e0;
        int w0;
        int i;
        int bad_sx [0:4] = '{0, 3, 33, 2, 0};
        int bad_sy [0:4] = '{3, 0, 2, 33, 0};
        rstn = 1'b1; start = 1'b0; mode = 1'b0; size_x = '0; size_y = '0;
        for (int j = 0; j < 64; j++) z_seen[j] = 16'hDEAD;
        repeat (3) tick();
        check_quiet("reset_outputs");
        rstn = 1'b0;
        tick();

        // T1 / T2: reference vectors in both modes, back-to-back.
        load_t1();
        push_exp(3, 2, 1'b0);
        launch(3, 2, 1'b0);
        wait_done(200);
        for (int j = 0; j < 4; j++) check_eq("t1_z", z_seen[j], t1_z[j]);
        push_exp(3, 2, 1'b1);
        launch(3, 2, 1'b1);
        wait_done(200);
        for (int j = 0; j < 4; j++) check_eq("t2_z", z_seen[j], t2_z[j]);

        // T3: rejected starts.
        for (int t = 0; t < 5; t++) begin
            e0 = err_cnt;
            size_x = (AW + 1)'(bad_sx[t]);
            size_y = (AW + 1)'(bad_sy[t]);
            start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("err_pulse", err, 1);
            for (int j = 0; j < 4; j++) begin
                tick();
                check_eq("no_activity_after_err", {memX_rd, memY_rd, writeZ, busy, done}, 0);
            end
            check_eq("err_once", err_cnt - e0, 1);
        end

        // Boundaries and random data.
        xmem[0] = 8'd7; ymem[0] = 8'd9;
        push_exp(1, 1, 1'b0);
        launch(1, 1, 1'b0);
        wait_done(50);
        check_eq("single_output", z_seen[0], 63);
        load_random();
        push_exp(5, 7, 1'b0); launch(5, 7, 1'b0); wait_done(400);
        push_exp(5, 7, 1'b1); launch(5, 7, 1'b1); wait_done(400);
        push_exp(32, 3, 1'b1); launch(32, 3, 1'b1); wait_done(800);
        push_exp(2, 32, 1'b0); launch(2, 32, 1'b0); wait_done(800);

        // T4: full-size all-ones run.
        for (int j = 0; j < 32; j++) begin
            xmem[j] = 8'hFF;
            ymem[j] = 8'hFF;
        end
        push_exp(32, 32, 1'b0);
        launch(32, 32, 1'b0);
        wait_done(3000);
`ifdef CONV_SAT_EN
        check_eq("t4_z31", z_seen[31], 16'hFFFF);
`else
        check_eq("t4_z31", z_seen[31], 16'hC020);
`endif
        check_eq("t4_z62", z_seen[62], 16'hFE01);

        // T6: reset during ISSUE of n=2, then a clean rerun with a start pulse while busy.
        load_t1();
        push_exp(3, 2, 1'b0);
        launch(3, 2, 1'b0);
        w0 = wr_cnt;
        i = 0;
        while (wr_cnt - w0 < 2 && i < 100) begin
            tick();
            i++;
        end
        check_eq("t6_reached_n2", wr_cnt - w0, 2);
        tick();
        check_eq("t6_mid_issue", memX_rd, 1);
        rstn = 1'b1;
        tick();
        check_quiet("t6_reset_outputs");
        rstn = 1'b0;
        sb.delete();
        repeat (10) tick();
        check_quiet("t6_no_activity");
        for (int j = 0; j < 4; j++) z_seen[j] = 16'hDEAD;
        e0 = err_cnt;
        push_exp(3, 2, 1'b0);
        launch(3, 2, 1'b0);
        tick();
        size_x = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        check_eq("t6_no_err_while_busy", err_cnt - e0, 0);
        for (int j = 0; j < 4; j++) check_eq("t6_z", z_seen[j], t1_z[j]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
